// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: ST7789V3 4-wire SPI (mode 0) transmitter fed by a valid/ready byte stream.
// Define LCD_SPI_BURST_EN to chain back-to-back bytes inside one CS-low frame.
module lcd_spi_tx #(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_SETUP   = 1,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  is_cmd,
    output logic                  spi_scl,
    output logic                  spi_sda,
    output logic                  spi_dc,
    output logic                  spi_cs,
    output logic                  busy
);

    localparam int BIT_W    = $clog2(WORD_WIDTH) + 1;
    localparam int DIV_W    = $clog2(CLK_DIV) + 1;
    localparam int WAIT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

    localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WORD_WIDTH - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic [WAIT_W-1:0]     r_wait;
    logic [WORD_WIDTH-1:0] r_shift;

    state_t                w_state_next;
    logic [DIV_W-1:0]      w_div_next;
    logic [BIT_W-1:0]      w_bit_next;
    logic [WAIT_W-1:0]     w_wait_next;
    logic [WORD_WIDTH-1:0] w_shift_next;
    logic                  w_dc_next;
    logic                  w_scl_next;
    logic                  w_sda_next;
    logic                  w_cs_next;
    logic                  w_accept;

    assign w_accept = valid & ready;
    assign busy     = (r_state != S_IDLE);

    // Handshake: ready depends only on state and reset.
    always_comb begin
        ready = 1'b0;
        if (rst) begin
            ready = 1'b0;
        end else if (r_state == S_IDLE) begin
            ready = 1'b1;
`ifdef LCD_SPI_BURST_EN
        end else if (r_state == S_HOLD) begin
            ready = 1'b1;
`endif
        end else begin
            ready = 1'b0;
        end
    end

    // Next-state, counters and pin values; pins are decoded from the current state and registered.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_wait_next  = r_wait;
        w_shift_next = r_shift;
        w_dc_next    = spi_dc;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_next = data;
                    w_dc_next    = ~is_cmd;
                    w_wait_next  = {WAIT_W{1'b0}};
                    w_state_next = S_SETUP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SETUP: begin
                if (r_wait == SETUP_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_bit_next   = {BIT_W{1'b0}};
                    w_state_next = S_SHIFT;
                end else begin
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            S_SHIFT: begin
                // End of the low-then-high bit period is the SCL falling edge.
                if (r_div == DIV_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_shift_next = r_shift << 1;
                    if (r_bit == BIT_LAST) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            S_HOLD: begin
`ifdef LCD_SPI_BURST_EN
                if (w_accept) begin
                    w_shift_next = data;
                    w_dc_next    = ~is_cmd;
                    w_div_next   = {DIV_W{1'b0}};
                    w_bit_next   = {BIT_W{1'b0}};
                    w_state_next = S_SHIFT;
                end else begin
                    w_wait_next  = {WAIT_W{1'b0}};
                    w_state_next = S_GAP;
                end
`else
                w_wait_next  = {WAIT_W{1'b0}};
                w_state_next = S_GAP;
`endif
            end
            S_GAP: begin
                if (r_wait == GAP_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_scl_next = (r_state == S_SHIFT) && (r_div >= DIV_HALF);
        w_sda_next = ((r_state == S_SETUP) || (r_state == S_SHIFT)) ? r_shift[WORD_WIDTH-1] : 1'b0;
        w_cs_next  = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
    end

    // State, counters and SPI pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= {DIV_W{1'b0}};
            r_bit   <= {BIT_W{1'b0}};
            r_wait  <= {WAIT_W{1'b0}};
            r_shift <= {WORD_WIDTH{1'b0}};
            spi_scl <= 1'b0;
            spi_sda <= 1'b0;
            spi_dc  <= 1'b1;
            spi_cs  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_wait  <= w_wait_next;
            r_shift <= w_shift_next;
            spi_scl <= w_scl_next;
            spi_sda <= w_sda_next;
            spi_dc  <= w_dc_next;
            spi_cs  <= w_cs_next;
        end
    end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Self-checking bench for lcd_spi_tx: a pin-level SPI monitor decodes bytes and is compared
// against the queue of bytes the handshake accepted (DC = ~is_cmd, MSB first).
module tb_lcd_spi_tx;

    localparam int W     = 8;
    localparam int DIV   = 2;
    localparam int SETUP = 1;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       is_cmd = 1'b0;
    logic       ready, spi_scl, spi_sda, spi_dc, spi_cs, busy;

    logic       valid1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       cmd1 = 1'b0;
    logic       ready1, scl1, sda1, dc1, cs1, busy1;

    int checks = 0;
    int errors = 0;

    lcd_spi_tx #(.WORD_WIDTH(W), .CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_GAP(GAP)) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data), .is_cmd(is_cmd),
        .spi_scl(spi_scl), .spi_sda(spi_sda), .spi_dc(spi_dc), .spi_cs(spi_cs), .busy(busy)
    );

    lcd_spi_tx #(.WORD_WIDTH(W), .CLK_DIV(1), .CS_SETUP(1), .CS_GAP(2)) u_dut_div1 (
        .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .data(data1), .is_cmd(cmd1),
        .spi_scl(scl1), .spi_sda(sda1), .spi_dc(dc1), .spi_cs(cs1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Pin monitor state
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    logic       m_prev_scl = 1'b0, m_prev_sda = 1'b0, m_prev_dc = 1'b1, m_prev_cs = 1'b1;
    logic [7:0] m_acc = 8'h00;
    int m_bits = 0, rises = 0, windows = 0, gap_run = 0, min_gap = 1000;
    int dc_cslow = 0, dc_sclhigh = 0, sda_glitch = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (spi_scl && !m_prev_scl) rises++;
            if (rst || spi_cs) begin
                m_bits = 0;
            end else if (spi_scl && !m_prev_scl) begin
                m_acc = {m_acc[6:0], spi_sda};
                m_bits++;
                if (m_bits == 8) begin
                    rx_q.push_back({spi_dc, m_acc});
                    m_bits = 0;
                end
            end
            if (!spi_cs && m_prev_cs) begin
                windows++;
                if (gap_run < min_gap) min_gap = gap_run;
            end
            gap_run = spi_cs ? gap_run + 1 : 0;
            if (spi_dc != m_prev_dc && !spi_cs) dc_cslow++;
            if (spi_dc != m_prev_dc && spi_scl) dc_sclhigh++;
            if (spi_scl && m_prev_scl && spi_sda != m_prev_sda) sda_glitch++;
            m_prev_scl = spi_scl;
            m_prev_sda = spi_sda;
            m_prev_dc  = spi_dc;
            m_prev_cs  = spi_cs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_mismatch();
        if (rx_q.size() != exp_q.size()) return -2;
        foreach (rx_q[i]) if (rx_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send(input logic [7:0] b, input logic c);
        int ok = 0;
        valid = 1'b1; data = b; is_cmd = c;
        for (int n = 0; n < 200; n++) begin
            if (ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        valid = 1'b0; data = 8'($urandom); is_cmd = 1'($urandom);
        if (ok == 1) begin
            exp_q.push_back({~c, b});
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %h not accepted, required accept within 200 cycles", b);
        end
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int n = 0; n < 400; n++) begin
            if (!busy && ready && spi_cs) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b ready=%b cs=%b, required idle within 400 cycles", busy, ready, spi_cs);
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data = 8'hFF; is_cmd = 1'b1;
        repeat (3) tick();
        checks++;
        if ({spi_scl, spi_sda, spi_dc, spi_cs, busy, ready} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_outputs: scl,sda,dc,cs,busy,ready=%b, required 001100",
                     {spi_scl, spi_sda, spi_dc, spi_cs, busy, ready});
        end
        checks++;
        if ({scl1, sda1, dc1, cs1, busy1, ready1} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_outputs_div1: got %b, required 001100", {scl1, sda1, dc1, cs1, busy1, ready1});
        end
        valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
        end
        begin
            int w0 = windows;
            int cs_bad = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (spi_cs !== 1'b1) cs_bad++;
            end
            checks++;
            if (cs_bad != 0 || windows != w0) begin
                errors++;
                $display("FAIL idle_cs: cs low samples=%0d new windows=%0d, required 0 and 0", cs_bad, windows - w0);
            end
        end
    endtask

    task automatic test_single_cmd();
        int r0, first_cs, first_rise, first_ready, mm;
        logic dc_mid;
        rx_q.delete(); exp_q.delete();
        r0 = rises; first_cs = -1; first_rise = -1; first_ready = -1; dc_mid = 1'bx;
        send(8'h11, 1'b1);
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (spi_cs === 1'b0 && first_cs < 0) first_cs = n;
            if (spi_scl === 1'b1 && first_rise < 0) first_rise = n;
            if (ready === 1'b1 && first_ready < 0) first_ready = n;
            if (n == 10) dc_mid = spi_dc;
        end
        checks++;
        if (first_cs != 1) begin
            errors++; $display("FAIL single_cs_fall: cycle %0d, required 1", first_cs);
        end
        checks++;
        if (first_rise != SETUP + DIV + 1) begin
            errors++; $display("FAIL single_first_rise: cycle %0d, required %0d", first_rise, SETUP + DIV + 1);
        end
        checks++;
        if (first_ready != SETUP + 2 * DIV * W + 1 + GAP) begin
            errors++; $display("FAIL single_ready_return: cycle %0d, required %0d", first_ready, SETUP + 2 * DIV * W + 1 + GAP);
        end
        checks++;
        if (dc_mid !== 1'b0) begin
            errors++; $display("FAIL single_dc: got %b, required 0", dc_mid);
        end
        checks++;
        if (rises - r0 != 8) begin
            errors++; $display("FAIL single_pulses: got %0d, required 8", rises - r0);
        end
        mm = first_mismatch();
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL single_bytes: rx %0d bytes exp %0d, mismatch code %0d", rx_q.size(), exp_q.size(), mm);
        end
    endtask

    task automatic test_clkdiv1();
        logic s[40];
        logic d[40];
        logic [7:0] acc = 8'h00;
        int f = -1, nr = 0, bad = 0;
        logic dc_at, cs_at;
        valid1 = 1'b1; data1 = 8'hA5; cmd1 = 1'b0;
        for (int n = 0; n < 20 && ready1 !== 1'b1; n++) tick();
        tick();
        valid1 = 1'b0; data1 = 8'h00;
        for (int i = 0; i < 40; i++) begin
            tick();
            s[i] = scl1;
            d[i] = sda1;
        end
        dc_at = dc1; cs_at = cs1;
        for (int i = 1; i < 40; i++) begin
            if (s[i] && !s[i-1]) begin
                nr++;
                acc = {acc[6:0], d[i]};
                if (f < 0) f = i;
                if (nr == 1) begin dc_at = dc1; cs_at = cs1; end
            end
        end
        checks++;
        if (nr != 8 || acc !== 8'hA5) begin
            errors++; $display("FAIL div1_bits: %0d pulses byte %h, required 8 pulses byte a5", nr, acc);
        end
        checks++;
        if (f != 2) begin
            errors++; $display("FAIL div1_first_rise: sample %0d, required 2", f);
        end
        if (f >= 0 && f + 16 < 40) begin
            for (int k = 0; k < 16; k++) if (s[f+k] !== ((k % 2) == 0)) bad++;
            if (s[f+16] !== 1'b0) bad++;
        end else begin
            bad = 99;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL div1_phases: %0d wrong phase samples, required 0", bad);
        end
        checks++;
        if (dc1 !== 1'b1 || busy1 !== 1'b0 || cs1 !== 1'b1) begin
            errors++; $display("FAIL div1_dc_end: dc=%b busy=%b cs=%b, required 1 0 1", dc1, busy1, cs1);
        end
    endtask

    task automatic test_back_to_back();
        int r0, w0, c0, h0, mm;
        rx_q.delete(); exp_q.delete();
        r0 = rises; w0 = windows; c0 = dc_cslow; h0 = dc_sclhigh; min_gap = 1000;
        send(8'h2A, 1'b1);
        send(8'h00, 1'b0);
        wait_idle();
        checks++;
        if (rises - r0 != 16) begin
            errors++; $display("FAIL b2b_pulses: got %0d, required 16", rises - r0);
        end
`ifdef LCD_SPI_BURST_EN
        checks++;
        if (windows - w0 != 1) begin
            errors++; $display("FAIL b2b_windows: got %0d, required 1", windows - w0);
        end
        checks++;
        if (dc_cslow - c0 != 1 || dc_sclhigh != h0) begin
            errors++; $display("FAIL b2b_dc_switch: cs-low changes %0d, scl-high changes %0d, required 1 and 0",
                               dc_cslow - c0, dc_sclhigh - h0);
        end
`else
        checks++;
        if (windows - w0 != 2 || min_gap < GAP) begin
            errors++; $display("FAIL b2b_windows: got %0d windows gap %0d, required 2 windows gap >= %0d",
                               windows - w0, min_gap, GAP);
        end
        checks++;
        if (dc_cslow != c0 || dc_sclhigh != h0) begin
            errors++; $display("FAIL b2b_dc_stable: cs-low changes %0d, required 0", dc_cslow - c0);
        end
`endif
        mm = first_mismatch();
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL b2b_bytes: rx %0d bytes exp %0d, mismatch code %0d", rx_q.size(), exp_q.size(), mm);
        end
    endtask

    task automatic test_reset_mid();
        int nr = 0, r1, mm;
        logic prev = 1'b0;
        rx_q.delete(); exp_q.delete();
        send(8'h96, 1'b0);
        for (int n = 0; n < 100 && nr < 3; n++) begin
            tick();
            if (spi_scl && !prev) nr++;
            prev = spi_scl;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (spi_cs !== 1'b1 || spi_scl !== 1'b0 || busy !== 1'b0 || spi_dc !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs: cs=%b scl=%b busy=%b dc=%b, required 1 0 0 1", spi_cs, spi_scl, busy, spi_dc);
        end
        rst = 1'b0;
        void'(exp_q.pop_back());
        r1 = rises;
        repeat (40) tick();
        checks++;
        if (rises != r1 || spi_cs !== 1'b1) begin
            errors++; $display("FAIL rst_mid_quiet: %0d extra pulses cs=%b, required 0 and 1", rises - r1, spi_cs);
        end
        send(8'h3C, 1'b0);
        wait_idle();
        mm = first_mismatch();
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL rst_mid_next_byte: rx %0d bytes exp %0d, mismatch code %0d", rx_q.size(), exp_q.size(), mm);
        end
    endtask

    task automatic test_stall();
        int acc = 0, mm, h0, g0;
        logic go;
        rx_q.delete(); exp_q.delete();
        h0 = dc_sclhigh; g0 = sda_glitch;
        for (int n = 0; n < 3000 && acc < 12; n++) begin
            valid  = 1'($urandom_range(0, 1));
            data   = 8'($urandom);
            is_cmd = 1'($urandom);
            go = valid & ready;
            if (go) exp_q.push_back({~is_cmd, data});
            tick();
            if (go) acc++;
        end
        valid = 1'b0;
        checks++;
        if (acc != 12) begin
            errors++; $display("FAIL stall_accepts: got %0d, required 12", acc);
        end
        wait_idle();
        mm = first_mismatch();
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL stall_bytes: rx %0d bytes exp %0d, mismatch code %0d", rx_q.size(), exp_q.size(), mm);
        end
        checks++;
        if (sda_glitch != g0 || dc_sclhigh != h0) begin
            errors++; $display("FAIL stall_stability: sda changes while scl high %0d, dc changes %0d, required 0 0",
                               sda_glitch - g0, dc_sclhigh - h0);
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_clkdiv1();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_spi_tx.md
# lcd_spi_tx

Serial transmit stage for the ST7789V3 LCD path. Consumes the byte stream produced by the command sequence decoder, buffered through the FIFO, over a valid/ready handshake. Serializes each byte MSB-first onto a 4-wire SPI bus in mode 0, driving DC from the byte's command/data flag and framing each transfer with chip select. It is the last stage before the LCD pins.

## Interface
- `WORD_WIDTH`, 8, bits per transfer.
- `CLK_DIV`, 2, system cycles per SCL half-period; must be ≥1.
- `CS_SETUP`, 1, cycles CS is low before the first SCL edge; must be ≥1.
- `CS_GAP`, 2, cycles CS is high between transfers; must be ≥1.
- `clk`  in  1  system clock; everything runs on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid`  in  1  upstream byte present.
- `ready`  out  1  block accepts a byte this cycle.
- `data`  in  WORD_WIDTH  byte to send.
- `is_cmd`  in  1  byte is a command, so DC goes low; otherwise DC goes high.
- `spi_scl`  out  1  serial clock, idle low.
- `spi_sda`  out  1  serial data, MSB first.
- `spi_dc`  out  1  data/command select.
- `spi_cs`  out  1  chip select, active low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All SPI outputs are registered.
- `ready` is combinational from state:
  - `ready = 0` while `rst` is high.
  - `ready = 1` in IDLE.
  - `ready = 1` in HOLD only when `LCD_SPI_BURST_EN` is defined.
- A byte transfers on any rising edge where `valid & ready` is high. `data` and `is_cmd` are captured into a shift register and a DC register. `valid` may drop at any time without effect while `ready` is low.
- States:
  - **IDLE**: `spi_cs=1`, `spi_scl=0`. On accept: load the shift register, set `spi_dc = ~is_cmd`, set `spi_cs = 0`, go to SETUP.
  - **SETUP**: hold for CS_SETUP cycles with `spi_sda` = shift MSB, then go to SHIFT.
  - **SHIFT**:
    - The divider counts CLK_DIV cycles per half-period.
    - SCL rises at the end of the first half and falls at the end of the second.
    - On each falling edge the shift register shifts left and `spi_sda` updates.
    - A bit counter counts WORD_WIDTH bits. After the last falling edge, go to HOLD.
  - **HOLD**: 1 cycle, `spi_scl=0`, CS still low. The exit depends on the configuration; see Configuration.
  - **GAP**: `spi_cs=1` for CS_GAP cycles, then go to IDLE.
- The bit counter is `$clog2(WORD_WIDTH)+1` bits wide. The divider counter is `$clog2(CLK_DIV)+1` bits wide. Neither counter wraps during normal operation.

## Timing
- Reset values: state IDLE, `spi_scl=0`, `spi_sda=0`, `spi_dc=1`, `spi_cs=1`, `busy=0`. `ready=0` during reset and 1 on the first cycle after `rst` falls.
- Taking the accept edge as cycle 0:
  - CS falls at cycle 1.
  - The first SCL rise occurs at cycle CS_SETUP+CLK_DIV+1.
  - SDA is stable for CLK_DIV cycles before each rise and after each rise.
- Non-burst per-byte period, from accept to the next possible accept: CS_SETUP + 2·CLK_DIV·WORD_WIDTH + 1 + CS_GAP cycles. With defaults this is 36.
- Burst back-to-back period: 2·CLK_DIV·WORD_WIDTH + 1 cycles. With defaults this is 33. There is no CS_SETUP and no gap.
- `spi_dc` changes only on an accept edge. It is therefore stable for the whole time CS is low for that byte.
- Reset mid-transfer: on the next edge all outputs return to their reset values, CS goes high immediately, and the in-flight byte is dropped. Nothing is retransmitted.
- Simultaneous `rst` and `valid`: reset wins and no byte is accepted.

## Configuration
- `LCD_SPI_BURST_EN` defined:
  - In HOLD, `ready=1`.
  - If `valid` is high, the new byte is captured, `spi_dc` is updated, CS stays low, and the block goes straight to SHIFT.
  - Otherwise CS rises and the block goes to GAP.
- `LCD_SPI_BURST_EN` undefined:
  - In HOLD, `ready=0`.
  - CS always rises and the block goes to GAP.
  - Every byte is framed by its own CS pulse.

## Test plan
- Reset then idle: all outputs equal their reset values; `ready=1` one cycle after `rst` drops; `spi_cs` stays 1 with no stimulus.
- Single command, `data=8'h11`, `is_cmd=1`, defaults: `spi_dc=0`; SDA sampled on SCL rises reads 0,0,0,1,0,0,0,1; exactly 8 SCL pulses; `ready` returns 36 cycles after accept.
- Data byte `8'hA5`, `is_cmd=0`, `CLK_DIV=1`: `spi_dc=1`; bits read 1,0,1,0,0,1,0,1; each SCL high and low phase is 1 cycle.
- Two bytes presented back-to-back (`8'h2A` cmd, then `8'h00` data):
  - Burst undefined: two CS-low windows with CS high for ≥2 cycles between them.
  - Burst defined: one continuous CS-low window, 16 SCL pulses, and DC switching 0→1 between bytes while SCL is low.
- Assert `rst` after the 3rd SCL rise: `spi_cs=1` and `spi_scl=0` on the next edge, no further SCL pulses, and a subsequent byte transmits correctly from its MSB.
- Upstream stall, with `valid` toggled randomly and `data` changed while `ready=0`: only bytes present on `valid & ready` edges appear on SDA, in order, with no duplicates.
